// File: rtl/dct_seq_pkg.sv
// Shared constants and types for the DCT-8 row sequencer.
package dct_seq_pkg;

  localparam int ROWS      = 8;
  localparam int ROW_CNT_W = $clog2(ROWS);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t LOCK0 = 2'd1;
  localparam state_t LOCK1 = 2'd2;

  typedef logic src_t;

endpackage

// File: rtl/dct_seq_out_reg.sv
// Valid/ready output holding register for one stage result plus its source/row/last tags.
// A load while the slot drains replaces the beat with no bubble; contents hold while stalled.
module dct_seq_out_reg
  import dct_seq_pkg::*;
#(
  parameter int DATA_W = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_W-1:0]    load_data,
  input  src_t                 load_src,
  input  logic [ROW_CNT_W-1:0] load_row,
  input  logic                 load_last,
  input  logic                 o_ready,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  output src_t                 o_src,
  output logic [ROW_CNT_W-1:0] o_row,
  output logic                 o_last
);

  logic [DATA_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  src_t                 src_q, src_d;
  logic [ROW_CNT_W-1:0] row_q, row_d;
  logic                 last_q, last_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    row_d   = row_q;
    last_d  = last_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
      src_d   = load_src;
      row_d   = load_row;
      last_d  = load_last;
    end else if (o_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      row_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      row_q   <= row_d;
      last_q  <= last_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_src   = src_q;
  assign o_row   = row_q;
  assign o_last  = last_q;

endmodule

// File: rtl/dct_8_row_sequencer.sv
// Shares one DCT-8 stage-1 butterfly between two requesters, granting whole 8-row blocks round-robin.
// Optional DCT_SEQ_PERF_EN adds saturating perf_blocks/perf_stalls counters.
module dct_8_row_sequencer
  import dct_seq_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int LANE_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    req0_data,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DATA_W-1:0]    req1_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  output logic [DATA_W-1:0]    stg_in,
  input  logic [DATA_W-1:0]    stg_out,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 o_src,
  output logic [ROW_CNT_W-1:0] o_row,
  output logic                 o_last,
  output logic                 busy
`ifdef DCT_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_blocks,
  output logic [31:0]          perf_stalls
`endif
);

  if (DATA_W != 8 * LANE_W) begin : g_cfg_check
    $error("DATA_W must hold exactly 8 lanes of LANE_W");
  end

  state_t               state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic [ROW_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic                 slot_free, accept, row_last, owner_valid;
  src_t                 owner;

  always_comb begin
    slot_free   = !o_valid || o_ready;
    owner       = (state_q == LOCK1);
    owner_valid = owner ? req1_valid : req0_valid;
    req0_ready  = (state_q == LOCK0) && slot_free;
    req1_ready  = (state_q == LOCK1) && slot_free;
    accept      = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    row_last    = (row_cnt_q == ROW_CNT_W'(ROWS - 1));
    busy        = (state_q != IDLE);

    case (state_q)
      LOCK0:   stg_in = req0_data;
      LOCK1:   stg_in = req1_data;
      default: stg_in = '0;
    endcase

    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      IDLE: begin
        // Grant is registered, so every block starts with one idle cycle.
        if (req0_valid && req1_valid) state_d = rr_ptr_q ? LOCK1 : LOCK0;
        else if (req0_valid)          state_d = LOCK0;
        else if (req1_valid)          state_d = LOCK1;
      end
      LOCK0, LOCK1: begin
        if (accept) begin
          if (row_last) begin
            row_cnt_d = '0;
            rr_ptr_d  = ~owner;
            state_d   = IDLE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  dct_seq_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_data(stg_out),
    .load_src (owner),
    .load_row (row_cnt_q),
    .load_last(row_last),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_src    (o_src),
    .o_row    (o_row),
    .o_last   (o_last)
  );

`ifdef DCT_SEQ_PERF_EN
  logic [31:0] perf_blocks_q, perf_blocks_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_blocks_d = perf_blocks_q;
    perf_stalls_d = perf_stalls_q;
    if (accept && row_last && (perf_blocks_q != '1)) perf_blocks_d = perf_blocks_q + 1'b1;
    if (busy && owner_valid && !slot_free && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_blocks_q <= perf_blocks_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_blocks = perf_blocks_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_dct_8_row_sequencer.sv
// Bench for dct_8_row_sequencer: cycle table for a single block, directed corner sequences,
// and a randomized run checked by a queue-based scoreboard of per-requester row streams.
module tb_dct_8_row_sequencer;

  localparam int DATA_W = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] req0_data, req1_data, stg_in, stg_out, o_data;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic              o_valid, o_ready, o_src, o_last, busy;
  logic [2:0]        o_row;
`ifdef DCT_SEQ_PERF_EN
  logic [31:0]       perf_blocks, perf_stalls;
`endif

  always #5 clk = ~clk;

  // Stage model: +1 per 64-bit lane.
  for (genvar l = 0; l < 8; l++) begin : g_stage
    assign stg_out[l*64 +: 64] = stg_in[l*64 +: 64] + 64'd1;
  end

  dct_8_row_sequencer #(.DATA_W(DATA_W), .LANE_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_data (req0_data),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req1_data (req1_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .stg_in    (stg_in),
    .stg_out   (stg_out),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_src     (o_src),
    .o_row     (o_row),
    .o_last    (o_last),
    .busy      (busy)
`ifdef DCT_SEQ_PERF_EN
    ,
    .perf_blocks(perf_blocks),
    .perf_stalls(perf_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: rows accepted per requester, block progress on each side.
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic              blk_srcs[$];
  int                acc_cnt, out_cnt, blocks_done;
  logic              acc_src, blk_src_o;

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] plus1(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int l = 0; l < 8; l++) r[l*64 +: 64] = d[l*64 +: 64] + 64'd1;
    return r;
  endfunction

  task automatic model_clear();
    q0.delete();
    q1.delete();
    blk_srcs.delete();
    acc_cnt = 0;
    out_cnt = 0;
    blocks_done = 0;
    acc_src = 1'b0;
    blk_src_o = 1'b0;
  endtask

  // Samples handshakes ahead of the next rising edge, updates the model, then moves to the falling edge.
  task automatic tick();
    logic a0, a1, s;
    logic [DATA_W-1:0] exp_row;
    #1;
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    if (rst) begin
      model_clear();
      a0 = 1'b0;
      a1 = 1'b0;
    end else begin
      chk("one_ready", req0_ready & req1_ready, 0);
      if (a0 || a1) begin
        s = a1;
        if (acc_cnt != 0) chk("grant_owner", s, acc_src);
        acc_src = s;
        if (s) q1.push_back(req1_data);
        else   q0.push_back(req0_data);
        acc_cnt++;
        if (acc_cnt == 8) begin
          acc_cnt = 0;
          blocks_done++;
        end
      end
      if (o_valid && o_ready) begin
        if (out_cnt == 0) begin
          blk_src_o = o_src;
          blk_srcs.push_back(o_src);
        end else begin
          chk("out_src", o_src, blk_src_o);
        end
        chk("out_row", o_row, out_cnt);
        chk("out_last", o_last, out_cnt == 7);
        if ((o_src ? q1.size() : q0.size()) == 0) begin
          chk("out_unexpected_beat", 1, 0);
        end else begin
          exp_row = o_src ? q1.pop_front() : q0.pop_front();
          chk("out_data", o_data, plus1(exp_row));
        end
        out_cnt = (out_cnt + 1) % 8;
      end
    end
    @(negedge clk);
    if (a0) req0_data = rnd();
    if (a1) req1_data = rnd();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    o_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       v0, v1, ordy;
    logic       rdy0, rdy1, ovld, bsy;
    logic [2:0] row;
    logic       last, src;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic found, d2, d5;
    logic [DATA_W-1:0] cap;
`ifdef DCT_SEQ_PERF_EN
    logic [31:0] p0;
`endif
    vec_t t;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    o_ready = 1'b1;
    req0_data = rnd();
    req1_data = rnd();
    model_clear();

    // One block from requester 0: idle gap, lock cycle, then 8 output beats.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    for (int c = 2; c <= 8; c++)
      tbl[c] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'(c - 2), 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    do_reset();
    #1;
    chk("reset_ctl", {o_valid, busy, req0_ready, req1_ready, o_src, o_last, o_row}, 0);
    chk("reset_data", o_data, 0);
`ifdef DCT_SEQ_PERF_EN
    chk("reset_perf", {perf_blocks, perf_stalls}, 0);
`endif

    for (int i = 0; i < 11; i++) begin
      t = tbl[i];
      req0_valid = t.v0;
      req1_valid = t.v1;
      o_ready = t.ordy;
      #1;
      chk($sformatf("table_cycle%0d", i),
          {req0_ready, req1_ready, o_valid, busy, t.ovld ? {o_row, o_last, o_src} : 5'd0},
          {t.rdy0, t.rdy1, t.ovld, t.bsy, t.ovld ? {t.row, t.last, t.src} : 5'd0});
      tick();
    end

    // Both requesters valid continuously: blocks must alternate 0,1,0,1.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 80 && blk_srcs.size() < 4; i++) tick();
    chk("alt_blocks_seen", blk_srcs.size() >= 4, 1);
    for (int i = 0; i < 4 && i < blk_srcs.size(); i++)
      chk($sformatf("alt_block%0d_src", i), blk_srcs[i], i % 2);

    // Downstream stall for 5 cycles at row 3.
    do_reset();
    req0_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_valid && o_row == 3'd3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("stall_reach_row3", found, 1);
    if (found) begin
      cap = o_data;
      o_ready = 1'b0;
`ifdef DCT_SEQ_PERF_EN
      p0 = perf_stalls;
`endif
      for (int k = 0; k < 5; k++) begin
        #1;
        chk("stall_req0_ready", req0_ready, 0);
        chk("stall_hold_tags", {o_valid, o_row}, {1'b1, 3'd3});
        chk("stall_hold_data", o_data, cap);
        tick();
      end
      o_ready = 1'b1;
      #1;
`ifdef DCT_SEQ_PERF_EN
      chk("stall_perf_count", perf_stalls - p0, 5);
`endif
    end
    for (int i = 0; i < 20; i++) begin
      req0_valid = (acc_cnt != 0);
      tick();
    end
    chk("stall_no_lost_rows", q0.size() + q1.size(), 0);

    // Owner bubbles at rows 2 and 5 must not hand the grant to requester 1.
    do_reset();
    req1_valid = 1'b1;
    d2 = 1'b0;
    d5 = 1'b0;
    for (int i = 0; i < 40 && blocks_done == 0; i++) begin
      if (acc_cnt == 2 && !d2) begin
        req0_valid = 1'b0;
        d2 = 1'b1;
      end else if (acc_cnt == 5 && !d5) begin
        req0_valid = 1'b0;
        d5 = 1'b1;
      end else begin
        req0_valid = 1'b1;
      end
      #1;
      chk("bubble_no_steal", req1_ready, 0);
      tick();
    end
    chk("bubble_block_done", {d5, blocks_done}, {1'b1, 32'd1});

    // Reset at row 4 of a requester-1 block; arbitration restarts at requester 0.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (o_valid && o_src && o_row == 3'd4) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("rst_reach_row4", found, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_clears", {o_valid, busy}, 0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("rst_restart", {found, o_src, o_row}, {1'b1, 1'b0, 3'd0});

    // Randomized traffic and back-pressure against the scoreboard.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      req0_valid = ($urandom_range(3) != 0);
      req1_valid = ($urandom_range(2) == 0);
      o_ready = ($urandom_range(3) != 0);
      tick();
    end
    o_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req0_valid = (acc_cnt != 0);
      req1_valid = (acc_cnt != 0);
      tick();
    end
    chk("rand_no_lost_rows", q0.size() + q1.size(), 0);
    chk("rand_block_boundary", {acc_cnt, out_cnt}, 0);
    chk("rand_blocks_nonzero", blocks_done > 10, 1);
`ifdef DCT_SEQ_PERF_EN
    chk("rand_perf_blocks", perf_blocks, blocks_done);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
